arcade_input_ctrl: RTL and testbench

ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

---
 rtl/arcade_input_ctrl.sv | 178 +++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_ctrl.sv
// -----------------------------------------------------------------------------
// arcade_input_ctrl
//   Merges a PS/2 keyboard and two joypads into the active-low input ports of
//   an arcade core. A start press (F1/F2 or pad start) also generates a single
//   coin pulse of fixed width, followed by a mandatory low gap.
//
// Ports
//   clk_sys     system clock, rising edge
//   reset_n     asynchronous active-low reset
//   ps2_key     [10] event toggle, [9] pressed, [8:0] scancode (bit 8 = E0)
//   joystick_0  player 1 pad: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2
//   joystick_1  player 2 pad, same layout, ORed with player 1
//   rotate      1 = rotated cabinet, directions remapped
//   in0         ~{2'b00, coin, fire, down, right, left, up}   (registered)
//   in1         ~{1'b0, start2, start1, 5'b00000}             (registered)
//   coin_busy   coin FSM not IDLE                              (registered)
// -----------------------------------------------------------------------------
module arcade_input_ctrl #(
   parameter logic [23:0] COIN_HIGH_CYC = 24'd2_400_000,
   parameter logic [23:0] COIN_GAP_CYC  = 24'd2_400_000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        rotate,
   output logic [7:0]  in0,
   output logic [7:0]  in1,
   output logic        coin_busy
);

   // key latch bit positions
   localparam int K_UP = 0, K_DN = 1, K_LT = 2, K_RT = 3;
   localparam int K_SP = 4, K_CT = 5, K_F1 = 6, K_F2 = 7;

   typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} coin_st_e;

   logic        primed_q, primed_d;
   logic        tgl_q, tgl_d;
   logic [7:0]  keys_q, keys_d;
   logic        start_prev_q, start_prev_d;
   coin_st_e    state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic [7:0]  in0_q, in0_d;
   logic [7:0]  in1_q, in1_d;
   logic        busy_q, busy_d;

   logic [15:0] joy;
   logic        fire, start1, start2, start_any, start_rise, coin;
   logic        up, down, left, right;
   logic        unused_joy;

   assign joy        = joystick_0 | joystick_1;
   assign unused_joy = ^joy[15:7];

   // ---------------------------------------------------------------- keyboard
   // The first cycle out of reset only captures the toggle, so a toggle that
   // happens to sit at 1 when reset releases is not taken as a key event.
   always_comb begin
      primed_d = 1'b1;
      tgl_d    = ps2_key[10];
      keys_d   = keys_q;
      if (primed_q && (ps2_key[10] != tgl_q)) begin
         if      (ps2_key[7:0] == 8'h75)  keys_d[K_UP] = ps2_key[9];
         else if (ps2_key[7:0] == 8'h72)  keys_d[K_DN] = ps2_key[9];
         else if (ps2_key[7:0] == 8'h6B)  keys_d[K_LT] = ps2_key[9];
         else if (ps2_key[7:0] == 8'h74)  keys_d[K_RT] = ps2_key[9];
         else if (ps2_key[8:0] == 9'h029) keys_d[K_SP] = ps2_key[9];
         else if (ps2_key[8:0] == 9'h014) keys_d[K_CT] = ps2_key[9];
         else if (ps2_key[8:0] == 9'h005) keys_d[K_F1] = ps2_key[9];
         else if (ps2_key[8:0] == 9'h006) keys_d[K_F2] = ps2_key[9];
      end
   end

   // ---------------------------------------------------------------- merge
   always_comb begin
      fire   = keys_q[K_SP] | keys_q[K_CT] | joy[4];
      start1 = keys_q[K_F1] | joy[5];
      start2 = keys_q[K_F2] | joy[6];
      if (rotate) begin
         up    = keys_q[K_LT] | joy[1];
         down  = keys_q[K_RT] | joy[0];
         left  = keys_q[K_DN] | joy[2];
         right = keys_q[K_UP] | joy[3];
      end else begin
         up    = keys_q[K_UP] | joy[3];
         down  = keys_q[K_DN] | joy[2];
         left  = keys_q[K_LT] | joy[1];
         right = keys_q[K_RT] | joy[0];
      end
   end

   // Edge detection is also suppressed in the priming cycle: start_prev then
   // loads the live start level, so a start held through reset never fires.
   assign start_any    = start1 | start2;
   assign start_rise   = primed_q & start_any & ~start_prev_q;
   assign start_prev_d = start_any;

   // ---------------------------------------------------------------- coin FSM
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 24'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Edges arriving outside IDLE are dropped, never queued.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start_rise) begin
               state_d = PULSE;
               cnt_d   = COIN_HIGH_CYC - 24'd1;
            end
         end
         PULSE: begin
            if (cnt_q == 24'd0) begin
               state_d = GAP;
               cnt_d   = COIN_GAP_CYC - 24'd1;
            end else begin
               cnt_d   = cnt_q - 24'd1;
            end
         end
         GAP: begin
            if (cnt_q == 24'd0) state_d = IDLE;
            else                cnt_d   = cnt_q - 24'd1;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 24'd0;
         end
      endcase
   end

   always_comb begin
      coin = (state_q == PULSE);
   end

   // ---------------------------------------------------------------- outputs
   // coin_busy is taken from the next state so the flop tracks the FSM
   // register exactly; coin in in0 follows one cycle later by design.
   always_comb begin
      in0_d  = ~{2'b00, coin, fire, down, right, left, up};
      in1_d  = ~{1'b0, start2, start1, 5'b00000};
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         primed_q     <= 1'b0;
         tgl_q        <= 1'b0;
         keys_q       <= 8'h00;
         start_prev_q <= 1'b0;
         in0_q        <= 8'hFF;
         in1_q        <= 8'hFF;
         busy_q       <= 1'b0;
      end else begin
         primed_q     <= primed_d;
         tgl_q        <= tgl_d;
         keys_q       <= keys_d;
         start_prev_q <= start_prev_d;
         in0_q        <= in0_d;
         in1_q        <= in1_d;
         busy_q       <= busy_d;
      end
   end

   assign in0       = in0_q;
   assign in1       = in1_q;
   assign coin_busy = busy_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arcade_input_ctrl
//   Directed stimulus against arcade_input_ctrl with COIN_HIGH_CYC=4 and
//   COIN_GAP_CYC=3. A timestamp-based model predicts in0/in1/coin_busy after
//   every clock edge; outputs are compared on every falling edge, plus a set
//   of literal expectations on the named scenarios.
// -----------------------------------------------------------------------------
module tb_arcade_input_ctrl;

   localparam int H = 4;
   localparam int G = 3;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] ps2_key = 11'h000;
   logic [15:0] joystick_0 = 16'h0000;
   logic [15:0] joystick_1 = 16'h0000;
   logic        rotate = 1'b0;
   logic [7:0]  in0, in1;
   logic        coin_busy;

   int checks = 0;
   int errors = 0;

   arcade_input_ctrl #(
      .COIN_HIGH_CYC(24'd4),
      .COIN_GAP_CYC (24'd3)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .ps2_key   (ps2_key),
      .joystick_0(joystick_0),
      .joystick_1(joystick_1),
      .rotate    (rotate),
      .in0       (in0),
      .in1       (in1),
      .coin_busy (coin_busy)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   // Keyboard state is a plain set of held keys. The coin is a single
   // timestamp: the edge index at which a pulse was accepted; PULSE covers
   // edges [ps, ps+H), GAP covers [ps+H, ps+H+G).
   logic [7:0] exp_in0 = 8'hFF, exp_in1 = 8'hFF;
   logic       exp_busy = 1'b0;
   bit         m_up, m_dn, m_lt, m_rt, m_sp, m_ct, m_f1, m_f2;
   bit         m_primed, m_tprev, m_sprev;
   int         m_e, m_ps;

   function automatic int st_after(input int k);
      if (k >= m_ps && k < m_ps + H)     return 1;
      if (k >= m_ps + H && k < m_ps + H + G) return 2;
      return 0;
   endfunction

   initial begin : model
      logic [15:0] j;
      bit f, s1, s2, u, d, l, r;
      int old;
      forever begin
         @(posedge clk_sys or negedge reset_n);
         if (!reset_n) begin
            {m_up, m_dn, m_lt, m_rt, m_sp, m_ct, m_f1, m_f2} = '0;
            m_primed = 0; m_tprev = 0; m_sprev = 0;
            m_e = 0; m_ps = -100000;
            exp_in0 = 8'hFF; exp_in1 = 8'hFF; exp_busy = 1'b0;
         end else begin
            old = st_after(m_e - 1);
            j   = joystick_0 | joystick_1;
            f   = m_sp | m_ct | j[4];
            s1  = m_f1 | j[5];
            s2  = m_f2 | j[6];
            if (!rotate) begin
               u = m_up | j[3]; d = m_dn | j[2]; l = m_lt | j[1]; r = m_rt | j[0];
            end else begin
               u = m_lt | j[1]; d = m_rt | j[0]; l = m_dn | j[2]; r = m_up | j[3];
            end
            exp_in0 = ~{2'b00, old == 1, f, d, r, l, u};
            exp_in1 = ~{1'b0, s2, s1, 5'b00000};
            if (m_primed && (s1 | s2) && !m_sprev && old == 0) m_ps = m_e;
            exp_busy = (st_after(m_e) != 0);
            m_sprev = s1 | s2;
            if (m_primed && ps2_key[10] != m_tprev) begin
               case (ps2_key[7:0])
                  8'h75: m_up = ps2_key[9];
                  8'h72: m_dn = ps2_key[9];
                  8'h6B: m_lt = ps2_key[9];
                  8'h74: m_rt = ps2_key[9];
                  default: begin
                     if (!ps2_key[8]) begin
                        if (ps2_key[7:0] == 8'h29) m_sp = ps2_key[9];
                        if (ps2_key[7:0] == 8'h14) m_ct = ps2_key[9];
                        if (ps2_key[7:0] == 8'h05) m_f1 = ps2_key[9];
                        if (ps2_key[7:0] == 8'h06) m_f2 = ps2_key[9];
                     end
                  end
               endcase
            end
            m_tprev  = ps2_key[10];
            m_primed = 1;
            m_e++;
         end
      end
   end

   // ---------------------------------------------------------------- compare
   int coin_cyc = 0;
   int pulses   = 0;
   initial begin : compare
      logic last5;
      last5 = 1'b1;
      forever begin
         @(negedge clk_sys);
         chk("in0", {24'd0, in0}, {24'd0, exp_in0});
         chk("in1", {24'd0, in1}, {24'd0, exp_in1});
         chk("coin_busy", {31'd0, coin_busy}, {31'd0, exp_busy});
         if (in0[5] == 1'b0) coin_cyc++;
         if (last5 && !in0[5]) pulses++;
         last5 = in0[5];
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic ps2_ev(input logic [8:0] code, input logic pressed);
      ps2_key = {~ps2_key[10], pressed, code};
   endtask

   initial begin : stim
      int c0, p0;
      logic [3:0] dirs [8];
      dirs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0101, 4'b1010, 4'b0001, 4'b1000};

      // reset with the toggle parked at 1 and an "up" press pending
      ps2_key = 11'h675;
      tick(3);
      reset_n = 1'b1;
      tick(10);
      chk("idle_in0", {24'd0, in0}, 32'hFF);
      chk("idle_in1", {24'd0, in1}, 32'hFF);
      chk("idle_busy", {31'd0, coin_busy}, 32'd0);

      // start1 via pad: 4-cycle coin, 7-cycle busy, no retrigger while held
      c0 = coin_cyc; p0 = pulses;
      joystick_0 = 16'h0020;
      tick(1);
      chk("start1_in1", {24'd0, in1}, 32'hDF);
      chk("start1_busy", {31'd0, coin_busy}, 32'd1);
      chk("start1_in0_pre", {24'd0, in0}, 32'hFF);
      tick(1);
      chk("coin_in0", {24'd0, in0}, 32'hDF);
      tick(14);
      chk("coin_cycles", coin_cyc - c0, 32'd4);
      chk("coin_pulses", pulses - p0, 32'd1);

      // start2 edges during PULSE and GAP are dropped
      joystick_0 = 16'h0000;
      tick(3);
      c0 = coin_cyc; p0 = pulses;
      joystick_1 = 16'h0040; tick(3);
      joystick_1 = 16'h0000; tick(1);
      joystick_1 = 16'h0040; tick(1);
      joystick_1 = 16'h0000; tick(1);
      joystick_1 = 16'h0040; tick(12);
      chk("s2_coin_cycles", coin_cyc - c0, 32'd4);
      chk("s2_pulses", pulses - p0, 32'd1);
      joystick_1 = 16'h0000;
      tick(3);

      // simultaneous start1+start2 edge gives one pulse
      c0 = coin_cyc; p0 = pulses;
      joystick_0 = 16'h0020; joystick_1 = 16'h0040;
      tick(12);
      chk("both_pulses", pulses - p0, 32'd1);
      chk("both_cycles", coin_cyc - c0, 32'd4);
      joystick_0 = 16'h0000; joystick_1 = 16'h0000;
      tick(3);

      // space + ctrl are independent fire latches; release up from reset first
      ps2_ev(9'h075, 1'b0); tick(3);
      ps2_ev(9'h029, 1'b1); tick(2);
      chk("fire_space", {31'd0, in0[4]}, 32'd0);
      ps2_ev(9'h014, 1'b1); tick(3);
      ps2_ev(9'h029, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("fire_ctrl_held", {31'd0, in0[4]}, 32'd0);
      end
      ps2_ev(9'h014, 1'b0);
      tick(1);
      chk("fire_rel_1", {31'd0, in0[4]}, 32'd0);
      tick(1);
      chk("fire_rel_2", {31'd0, in0[4]}, 32'd1);

      // rotated up arrow (E0 75) lands on right, then un-rotate
      rotate = 1'b1;
      ps2_ev(9'h175, 1'b1); tick(2);
      chk("rot_right", {28'd0, in0[3:0]}, 32'hB);
      rotate = 1'b0; tick(1);
      chk("norot_up", {28'd0, in0[3:0]}, 32'hE);
      ps2_ev(9'h175, 1'b0); tick(3);

      // unmapped code does nothing
      ps2_ev(9'h01C, 1'b1); tick(3);
      chk("unmapped", {24'd0, in0}, 32'hFF);

      // pad directions under both orientations
      joystick_0 = 16'h0008; rotate = 1'b1; tick(1);
      chk("pad_rot_up", {24'd0, in0}, 32'hFB);
      for (int i = 0; i < 8; i++) begin
         joystick_1 = {12'd0, dirs[i]};
         rotate = i[0];
         tick(1);
      end
      joystick_0 = 16'h0000; joystick_1 = 16'h0000; rotate = 1'b0;
      tick(2);

      // F1 via keyboard triggers a coin too
      p0 = pulses;
      ps2_ev(9'h005, 1'b1); tick(12);
      chk("f1_pulse", pulses - p0, 32'd1);
      ps2_ev(9'h005, 1'b0); tick(3);

      // reset mid-PULSE with start held through it
      joystick_0 = 16'h0020;
      tick(2);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_async_in0", {24'd0, in0}, 32'hFF);
      chk("rst_async_busy", {31'd0, coin_busy}, 32'd0);
      tick(2);
      reset_n = 1'b1;
      p0 = pulses;
      tick(10);
      chk("rst_no_resume", pulses - p0, 32'd0);
      chk("rst_busy_idle", {31'd0, coin_busy}, 32'd0);
      joystick_0 = 16'h0000; tick(2);
      joystick_0 = 16'h0020; tick(12);
      chk("rst_fresh_edge", pulses - p0, 32'd1);
      joystick_0 = 16'h0000; tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
